// File: rtl/dir_rot_hist.sv
// dir_rot_hist: rotates sample directions to the keypoint frame, bins them and drains a per-subregion magnitude histogram
module dir_rot_hist #(
    parameter int NDIR_IN = 36,
    parameter int NBINS   = 8,
    parameter int NSUB    = 16,
    parameter int DIR_W   = 6,
    parameter int MAG_W   = 8,
    parameter int ACC_W   = 16,
    localparam int SW     = $clog2(NSUB),
    localparam int IW     = $clog2(NSUB * NBINS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DIR_W-1:0] s_dir,
    input  logic [MAG_W-1:0] s_mag,
    input  logic [SW-1:0]    s_sub,
    input  logic             s_last,
    input  logic [DIR_W-1:0] dir_main,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic [IW-1:0]    m_idx,
    output logic             m_last,
    output logic             err
);
    localparam int NW = NSUB * NBINS;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [DIR_W-1:0] main_q, main_d, main_use, rel;
    logic [IW-1:0]    ptr_q, ptr_d, s1_addr_q, s1_addr_d;
    logic [MAG_W-1:0] s1_mag_q;
    logic             s1_vld_q, s1_vld_d, err_q, err_d;
    logic [ACC_W-1:0] acc_q [NW];
    logic [ACC_W-1:0] acc_d [NW];
    logic [ACC_W:0]   sum;
    logic [31:0]      bin_raw, bin;
    logic             take, drop, m_hs;

    assign s_ready = state_q == IDLE || state_q == ACCUM;
    assign take    = s_valid && s_ready;
    assign m_valid = state_q == DRAIN;
    assign m_hs    = m_valid && m_ready;
    assign m_data  = m_valid ? acc_q[ptr_q] : '0;
    assign m_idx   = ptr_q;
    assign m_last  = m_valid && 32'(ptr_q) == NW - 1;
    assign err     = err_q;

    // stage 0: rotate against the main direction, pick the centred bin, flag out-of-range beats
    always_comb begin
        main_use  = state_q == IDLE ? dir_main : main_q;
        rel       = s_dir >= main_use ? s_dir - main_use : DIR_W'(32'(s_dir) + NDIR_IN - 32'(main_use));
        bin_raw   = (32'(rel) * (2 * NBINS) + NDIR_IN) / (2 * NDIR_IN);
        bin       = bin_raw >= NBINS ? 32'd0 : bin_raw;
        drop      = 32'(s_dir) >= NDIR_IN || 32'(s_sub) >= NSUB;
        s1_addr_d = IW'(32'(s_sub) * NBINS + bin);
        s1_vld_d  = take && !drop;
        err_d     = take && drop;
        main_d    = state_q == IDLE && take ? dir_main : main_q;
    end

    // frame sequencing and drain pointer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: state_d = take ? (s_last ? FLUSH : ACCUM) : state_q;
            FLUSH:       state_d = DRAIN;
            DRAIN:       state_d = m_hs && 32'(ptr_q) == NW - 1 ? IDLE : DRAIN;
            default:     state_d = IDLE;
        endcase
        ptr_d = m_hs ? (32'(ptr_q) == NW - 1 ? '0 : ptr_q + 1'b1) : ptr_q;
    end

    // stage 2 saturating accumulate; drained words are cleared for the next frame
    always_comb begin
        acc_d = acc_q;
        sum   = {1'b0, acc_q[s1_addr_q]} + (ACC_W + 1)'(s1_mag_q);
        if (s1_vld_q) acc_d[s1_addr_q] = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        if (m_hs) acc_d[ptr_q] = '0;
    end

    // all state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            main_q    <= '0;
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_mag_q  <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NW; i++) acc_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_mag_q  <= s_mag;
            err_q     <= err_d;
            acc_q     <= acc_d;
        end
    end
endmodule

// File: tb/tb_dir_rot_hist.sv
// tb_dir_rot_hist: randomized scoreboard bench for the descriptor histogram accumulator
module tb_dir_rot_hist;
    localparam int NDIR = 36, NB = 8, NS = 16, NW = NS * NB, AMAX = 65535;

    logic       clk = 0, rst = 1;
    logic       s_valid = 0, s_last = 0, m_ready = 1;
    logic [5:0] s_dir = 0, dir_main = 0;
    logic [7:0] s_mag = 0;
    logic [3:0] s_sub = 0;
    logic       s_ready, m_valid, m_last, err;
    logic [15:0] m_data;
    logic [6:0]  m_idx;

    dir_rot_hist dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_dir(s_dir),
        .s_mag(s_mag), .s_sub(s_sub), .s_last(s_last), .dir_main(dir_main),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .m_last(m_last), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; int data; bit last;} word_t;
    word_t exp_q[$];
    int total = 0, bad = 0;
    int model[NW];
    int cur_main = 0, exp_err = 0, seen_err = 0, rmode = 0, ppos = 0;
    bit first = 1;

    task automatic chk(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic start_frame(int main);
        cur_main = main;
        first    = 1;
        exp_err  = 0;
        seen_err = 0;
    endtask

    // reference: rotate with modular arithmetic, nearest of NB centred sectors, saturating sum
    task automatic send(int dir, int mag, int sub, bit last);
        int rel, b, a;
        s_valid  = 1;
        s_dir    = 6'(dir);
        s_mag    = 8'(mag);
        s_sub    = 4'(sub);
        s_last   = last;
        dir_main = first ? 6'(cur_main) : 6'($urandom_range(0, 35));
        @(posedge clk);
        #1;
        s_valid = 0;
        s_last  = 0;
        first   = 0;
        if (dir >= NDIR || sub >= NS) exp_err++;
        else begin
            rel = (dir - cur_main + NDIR) % NDIR;
            b   = ((2 * rel * NB + NDIR) / (2 * NDIR)) % NB;
            a   = sub * NB + b;
            model[a] = (model[a] + mag > AMAX) ? AMAX : model[a] + mag;
        end
        if (last) begin
            for (int i = 0; i < NW; i++) begin
                exp_q.push_back('{i, model[i], i == NW - 1});
                model[i] = 0;
            end
        end
    endtask

    task automatic end_check(string tag);
        int n = 0;
        chk({tag, "_flush_gap"}, m_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_drain_start"}, m_valid, 1);
        while (exp_q.size() > 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) chk({tag, "_drain_timeout"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk({tag, "_idle_ready"}, s_ready, 1);
        chk({tag, "_err_pulses"}, seen_err, exp_err);
    endtask

    task automatic rand_frame(string tag);
        int n = $urandom_range(1, 40);
        start_frame($urandom_range(0, 35));
        for (int i = 0; i < n; i++)
            send(($urandom_range(0, 9) == 0) ? $urandom_range(36, 63) : $urandom_range(0, 35),
                 $urandom_range(0, 255), $urandom_range(0, 15), i == n - 1);
        end_check(tag);
    endtask

    // downstream ready: always, random, or the repeating 1,0,0,1 pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : (ppos % 4 == 1 || ppos % 4 == 2) ? 1'b0 : 1'b1;
            ppos++;
        end
    end

    // monitor: every handshake pops one expected word
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err) seen_err++;
                if (m_valid) begin
                    chk("s_ready_in_drain", s_ready, 0);
                    if (m_ready) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_word idx=%0d data=%0d", m_idx, m_data);
                        end else begin
                            w = exp_q.pop_front();
                            chk($sformatf("data[%0d]", w.idx), m_data, w.data);
                            chk($sformatf("idx[%0d]", w.idx), m_idx, w.idx);
                            chk($sformatf("last[%0d]", w.idx), m_last, w.last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < NW; i++) model[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_err", err, 0);
        rst = 0;
        #1;
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        start_frame(30);
        send(30, 5, 0, 0);
        send(29, 3, 0, 0);
        send(2, 7, 0, 1);
        end_check("rot");
        start_frame(0);
        for (int d = 0; d < NDIR; d++) send(d, 1, 3, d == NDIR - 1);
        end_check("table");
        start_frame(0);
        for (int i = 0; i < 300; i++) send(9, 255, 15, i == 299);
        end_check("sat");
        rmode = 2;
        rand_frame("bp");
        rmode = 0;
        rand_frame("after_bp");
        start_frame(5);
        send(10, 3, 2, 0);
        send(40, 9, 2, 0);
        send(63, 1, 0, 0);
        send(7, 4, 2, 0);
        send(40, 2, 1, 1);
        end_check("drop");
        rmode = 1;
        for (int k = 0; k < 4; k++) rand_frame($sformatf("rand%0d", k));
        rmode = 0;
        start_frame($urandom_range(0, 35));
        for (int i = 0; i < 20; i++) send($urandom_range(0, 35), $urandom_range(1, 255), $urandom_range(0, 15), i == 19);
        n = 0;
        while (exp_q.size() > NW - 50 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("mid_rst_s_ready", s_ready, 1);
        start_frame(0);
        send(0, 1, 0, 1);
        end_check("post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
